// File: rtl/ethernet_sys_mem_pkg.sv
// Shared types and default widths for the on-chip memory arbiter.
// Owner-state encoding and the default memory port geometry.
package ethernet_sys_mem_pkg;

  localparam int ADDR_W_DEFAULT = 13;
  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_M0 = 2'd1,
    OWN_M1 = 2'd2
  } owner_e;

endpackage

// File: rtl/ethernet_sys_onchip_mem_arbiter.sv
// Two-master arbiter in front of a single-port on-chip memory.
// Commands are accepted in the cycle they are granted; reads complete one cycle later.
module ethernet_sys_onchip_mem_arbiter
  import ethernet_sys_mem_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int BE_W   = DATA_W / 8;
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  owner_e            state_r, state_nxt_s;
  logic [HOLD_W-1:0] hold_r, hold_nxt_s;
  logic              last_m1_r, last_m1_nxt_s;  // 1: m1 was served most recently
  logic [1:0]        rsp_r, rsp_nxt_s;
  logic              req0_s, req1_s, gnt0_s, gnt1_s, hold_ok_s;

  // Grant decision and next owner/hold/response-tag state
  always_comb begin
    req0_s        = m0_read | m0_write;
    req1_s        = m1_read | m1_write;
    hold_ok_s     = (hold_r < HOLD_LAST);
    gnt0_s        = 1'b0;
    gnt1_s        = 1'b0;
    state_nxt_s   = IDLE;
    hold_nxt_s    = {HOLD_W{1'b0}};
    last_m1_nxt_s = last_m1_r;
    rsp_nxt_s     = 2'b00;

    if (reset) begin
      gnt0_s = 1'b0;
    end else if ((state_r == OWN_M0) && req0_s && (hold_ok_s || !req1_s)) begin
      gnt0_s = 1'b1;
    end else if ((state_r == OWN_M1) && req1_s && (hold_ok_s || !req0_s)) begin
      gnt1_s = 1'b1;
    end else if (req0_s && req1_s) begin
      if (last_m1_r) begin
        gnt0_s = 1'b1;
      end else begin
        gnt1_s = 1'b1;
      end
    end else if (req0_s) begin
      gnt0_s = 1'b1;
    end else if (req1_s) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
    end

    // Hold count saturates so a lone owner can keep streaming indefinitely
    if (gnt0_s) begin
      state_nxt_s   = OWN_M0;
      last_m1_nxt_s = 1'b0;
      rsp_nxt_s[0]  = m0_read & ~m0_write;
      if (state_r == OWN_M0) begin
        hold_nxt_s = hold_ok_s ? (hold_r + HOLD_W'(1)) : hold_r;
      end else begin
        hold_nxt_s = {HOLD_W{1'b0}};
      end
    end else if (gnt1_s) begin
      state_nxt_s   = OWN_M1;
      last_m1_nxt_s = 1'b1;
      rsp_nxt_s[1]  = m1_read & ~m1_write;
      if (state_r == OWN_M1) begin
        hold_nxt_s = hold_ok_s ? (hold_r + HOLD_W'(1)) : hold_r;
      end else begin
        hold_nxt_s = {HOLD_W{1'b0}};
      end
    end else begin
      state_nxt_s = IDLE;
    end
  end

  // Owner, hold counter, last-served pointer and read response tag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      hold_r    <= {HOLD_W{1'b0}};
      last_m1_r <= 1'b1;
      rsp_r     <= 2'b00;
    end else begin
      state_r   <= state_nxt_s;
      hold_r    <= hold_nxt_s;
      last_m1_r <= last_m1_nxt_s;
      rsp_r     <= rsp_nxt_s;
    end
  end

  // Memory command mux from the granted master
  always_comb begin
    case ({gnt1_s, gnt0_s})
      2'b01: begin
        mem_chipselect = 1'b1;
        mem_write      = m0_write;
        mem_address    = m0_address;
        mem_byteenable = m0_byteenable;
        mem_writedata  = m0_writedata;
      end
      2'b10: begin
        mem_chipselect = 1'b1;
        mem_write      = m1_write;
        mem_address    = m1_address;
        mem_byteenable = m1_byteenable;
        mem_writedata  = m1_writedata;
      end
      default: begin
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = {ADDR_W{1'b0}};
        mem_byteenable = {BE_W{1'b0}};
        mem_writedata  = {DATA_W{1'b0}};
      end
    endcase
  end

  assign m0_waitrequest   = reset | (req0_s & ~gnt0_s);
  assign m1_waitrequest   = reset | (req1_s & ~gnt1_s);
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rsp_r[0] & ~reset;
  assign m1_readdatavalid = rsp_r[1] & ~reset;

endmodule

// File: tb/tb_ethernet_sys_onchip_mem_arbiter.sv
// Directed bench for the two-master memory arbiter with a behavioural
// latency-1 memory (registered address, combinational data out).
module tb_ethernet_sys_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [12:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write;
  logic [31:0] mem_writedata, mem_readdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ethernet_sys_onchip_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
  );

  // Memory model: address registered on every command, byte-masked writes
  logic [31:0] mem_arr [0:8191];
  logic [12:0] mem_addr_r = 13'd0;
  always @(posedge clk) begin
    if (mem_chipselect) begin
      mem_addr_r <= mem_address;
      if (mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable[b]) mem_arr[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
      end
    end
  end
  assign mem_readdata = mem_arr[mem_addr_r];

  typedef struct {
    logic r0, w0; logic [12:0] a0; logic [3:0] be0; logic [31:0] d0;
    logic r1, w1; logic [12:0] a1; logic [3:0] be1; logic [31:0] d1;
    logic ew0, ew1, ecs, ewe; logic [12:0] eaddr; logic ev0, ev1; logic [31:0] edata;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_read = 1'b0; m0_write = 1'b0; m0_address = 13'd0; m0_byteenable = 4'h0; m0_writedata = 32'd0;
    m1_read = 1'b0; m1_write = 1'b0; m1_address = 13'd0; m1_byteenable = 4'h0; m1_writedata = 32'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reset for one edge with both masters requesting; outputs must be quiet
  task automatic do_reset(input string tag);
    reset = 1'b1;
    idle_inputs();
    m0_read = 1'b1;
    m1_read = 1'b1;
    @(negedge clk);
    check({tag, " rst wait0"}, 32'(m0_waitrequest), 32'd1);
    check({tag, " rst wait1"}, 32'(m1_waitrequest), 32'd1);
    check({tag, " rst cs"}, 32'(mem_chipselect), 32'd0);
    check({tag, " rst rdv0"}, 32'(m0_readdatavalid), 32'd0);
    check({tag, " rst rdv1"}, 32'(m1_readdatavalid), 32'd0);
    next_cycle();
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    logic exp_m0 [9];
    int   accepts;

    reset = 1'b1;
    idle_inputs();
    do_reset("init");

    // Preload two locations through m1, then reset so m0 wins the first tie
    m1_write = 1'b1; m1_byteenable = 4'hF; m1_address = 13'h0001; m1_writedata = 32'hA5A50001;
    @(negedge clk);
    check("preload cs0", 32'(mem_chipselect), 32'd1);
    next_cycle();
    m1_address = 13'h1FFF; m1_writedata = 32'h5A5A1FFF;
    @(negedge clk);
    check("preload cs1", 32'(mem_chipselect), 32'd1);
    next_cycle();
    do_reset("pre");

    tbl[0]  = '{1'b1, 1'b0, 13'h0001, 4'h0, 32'h0, 1'b1, 1'b0, 13'h1FFF, 4'h0, 32'h0,
                1'b0, 1'b1, 1'b1, 1'b0, 13'h0001, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 13'h0000, 4'h0, 32'h0, 1'b1, 1'b0, 13'h1FFF, 4'h0, 32'h0,
                1'b0, 1'b0, 1'b1, 1'b0, 13'h1FFF, 1'b1, 1'b0, 32'hA5A50001};
    tbl[2]  = '{1'b0, 1'b0, 13'h0000, 4'h0, 32'h0, 1'b0, 1'b0, 13'h0000, 4'h0, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b1, 32'h5A5A1FFF};
    tbl[3]  = '{1'b0, 1'b1, 13'h0010, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 13'h0000, 4'h0, 32'h0,
                1'b0, 1'b0, 1'b1, 1'b1, 13'h0010, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 13'h0010, 4'hF, 32'h0, 1'b0, 1'b0, 13'h0000, 4'h0, 32'h0,
                1'b0, 1'b0, 1'b1, 1'b0, 13'h0010, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 1'b1, 13'h0020, 4'hF, 32'hFFFFFFFF, 1'b0, 1'b0, 13'h0000, 4'h0, 32'h0,
                1'b0, 1'b0, 1'b1, 1'b1, 13'h0020, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[6]  = '{1'b0, 1'b1, 13'h0020, 4'h3, 32'h12345678, 1'b0, 1'b0, 13'h0000, 4'h0, 32'h0,
                1'b0, 1'b0, 1'b1, 1'b1, 13'h0020, 1'b0, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 13'h0020, 4'hF, 32'h0, 1'b0, 1'b0, 13'h0000, 4'h0, 32'h0,
                1'b0, 1'b0, 1'b1, 1'b0, 13'h0020, 1'b0, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 1'b0, 13'h0000, 4'h0, 32'h0, 1'b1, 1'b1, 13'h0030, 4'hF, 32'hCAFEF00D,
                1'b0, 1'b0, 1'b1, 1'b1, 13'h0030, 1'b1, 1'b0, 32'hFFFF5678};
    tbl[9]  = '{1'b0, 1'b0, 13'h0000, 4'h0, 32'h0, 1'b0, 1'b0, 13'h0000, 4'h0, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 1'b0, 13'h0000, 4'h0, 32'h0, 1'b1, 1'b0, 13'h0030, 4'hF, 32'h0,
                1'b0, 1'b0, 1'b1, 1'b0, 13'h0030, 1'b0, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 1'b0, 13'h0000, 4'h0, 32'h0, 1'b0, 1'b0, 13'h0000, 4'h0, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b1, 32'hCAFEF00D};

    for (int i = 0; i < 12; i++) begin
      m0_read = tbl[i].r0; m0_write = tbl[i].w0; m0_address = tbl[i].a0;
      m0_byteenable = tbl[i].be0; m0_writedata = tbl[i].d0;
      m1_read = tbl[i].r1; m1_write = tbl[i].w1; m1_address = tbl[i].a1;
      m1_byteenable = tbl[i].be1; m1_writedata = tbl[i].d1;
      @(negedge clk);
      check($sformatf("row%0d wait0", i), 32'(m0_waitrequest), 32'(tbl[i].ew0));
      check($sformatf("row%0d wait1", i), 32'(m1_waitrequest), 32'(tbl[i].ew1));
      check($sformatf("row%0d cs", i), 32'(mem_chipselect), 32'(tbl[i].ecs));
      check($sformatf("row%0d mem_write", i), 32'(mem_write), 32'(tbl[i].ewe));
      check($sformatf("row%0d mem_address", i), 32'(mem_address), 32'(tbl[i].eaddr));
      check($sformatf("row%0d rdv0", i), 32'(m0_readdatavalid), 32'(tbl[i].ev0));
      check($sformatf("row%0d rdv1", i), 32'(m1_readdatavalid), 32'(tbl[i].ev1));
      if (tbl[i].ev0) check($sformatf("row%0d rdata0", i), m0_readdata, tbl[i].edata);
      if (tbl[i].ev1) check($sformatf("row%0d rdata1", i), m1_readdata, tbl[i].edata);
      next_cycle();
    end
    idle_inputs();

    // Continuous contention: four grants each, then hand back
    do_reset("hold");
    for (int k = 0; k < 9; k++) exp_m0[k] = (k < 4) || (k == 8);
    m0_read = 1'b1; m0_address = 13'h0002;
    m1_read = 1'b1; m1_address = 13'h0003;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check($sformatf("hold%0d wait0", k), 32'(m0_waitrequest), 32'(!exp_m0[k]));
      check($sformatf("hold%0d wait1", k), 32'(m1_waitrequest), 32'(exp_m0[k]));
      if (k > 0) check($sformatf("hold%0d rdv0", k), 32'(m0_readdatavalid), 32'(exp_m0[k-1]));
      next_cycle();
    end
    idle_inputs();

    // Reset right after an accepted read drops the response and restores the tie-break
    do_reset("mid");
    m0_read = 1'b1; m0_address = 13'h0010;
    @(negedge clk);
    check("mid accept cs", 32'(mem_chipselect), 32'd1);
    next_cycle();
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    check("mid rst rdv0", 32'(m0_readdatavalid), 32'd0);
    check("mid rst wait0", 32'(m0_waitrequest), 32'd1);
    check("mid rst wait1", 32'(m1_waitrequest), 32'd1);
    check("mid rst cs", 32'(mem_chipselect), 32'd0);
    next_cycle();
    reset = 1'b0;
    m0_read = 1'b1; m1_read = 1'b1;
    @(negedge clk);
    check("mid post rdv0", 32'(m0_readdatavalid), 32'd0);
    check("mid post rdv1", 32'(m1_readdatavalid), 32'd0);
    check("mid post wait0", 32'(m0_waitrequest), 32'd0);
    check("mid post wait1", 32'(m1_waitrequest), 32'd1);
    next_cycle();
    idle_inputs();

    // Lone m1 streams without the hold limit kicking in
    do_reset("solo");
    accepts = 0;
    for (int k = 0; k < 10; k++) begin
      m1_read = 1'b1; m1_address = 13'(13'h0040 + k);
      @(negedge clk);
      check($sformatf("solo%0d wait1", k), 32'(m1_waitrequest), 32'd0);
      check($sformatf("solo%0d addr", k), 32'(mem_address), 32'(13'h0040 + k));
      if (k > 0) check($sformatf("solo%0d rdv1", k), 32'(m1_readdatavalid), 32'd1);
      if (mem_chipselect && !m1_waitrequest) accepts++;
      next_cycle();
    end
    idle_inputs();
    check("solo accepts", 32'(accepts), 32'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
